bfp_dot_accum: RTL and testbench
================================

Name: bfp_dot_accum

Overview:
Parametrised successor to the block-floating-point vector-product stage. It consumes two streams of P-lane BFP mantissa chunks, A and B, each chunk carrying its block's shared exponent. It multiplies lane-wise, reduces each beat through an adder tree and accumulates across a runtime-variable number of beats. It emits one signed dot product plus a combined exponent per vector. The block sits after the two mantissa-adjust stages and adds the following over the previous stage:
- valid/ready backpressure on both inputs and the output
- runtime vector length via last flags
- a pipelined multiply stage
- exponent overflow/underflow flagging

Parameters:
- V, 8: maximum elements per vector; must be a multiple of P.
- P, 4: lanes per beat.
- BIT, 32: source float width.
- FPM, 23: source float mantissa bits. EW = BIT-FPM-1 is the exponent width.
- BFPM, 4: BFP fraction bits. Mantissa word MW = BFPM+2, laid out as [MW-1] sign, [BFPM:0] magnitude including the hidden bit.
- Derived, not overridable: OW = 2*MW + clog2(V) is the result width; BIAS = 2^(EW-1)-1.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- a_valid  in  1  A chunk valid
- a_ready  out  1  A chunk accepted when a_valid&a_ready
- a_mants  in  P*MW  A lane mantissas, lane 0 in the LSBs
- a_exp  in  EW  A block exponent (biased)
- a_last  in  1  final A chunk of the vector
- b_valid, b_ready, b_mants, b_exp, b_last  same as the A set, for channel B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_prod  out  OW  two's-complement dot product
- out_exp  out  EW  combined biased exponent
- out_err  out  1  exponent saturated or last-flag mismatch

Behaviour:
Reset (reset=0, asynchronous):
- state=ACC; all pipeline and accumulator registers cleared.
- a_ready=b_ready=0 while reset is asserted; out_valid=0, out_prod=0, out_exp=0, out_err=0.

Join handshake:
- A beat fires only when a_valid & b_valid & (state==ACC).
- a_ready = b_ready = (state==ACC) & a_valid & b_valid.
- One channel valid alone consumes nothing.

Stage 1 (multiply):
- On fire, each lane computes mag = |a|*|b| (2*(BFPM+1) bits) and sign = sa^sb.
- The result is registered as a signed product with prod_valid=1. prod_valid=0 on cycles with no fire.

Stage 2 (accumulate):
- When prod_valid=1, the P products are summed in a combinational adder tree and added to acc (OW bits, signed).
- No overflow is possible for beat counts up to V/P.

Exponents:
- a_exp and b_exp are captured on the first beat of each vector; later beats' exponents are ignored.
- Combined exponent e = a_exp + b_exp - BIAS, computed in EW+2 signed bits.
- e > 2^EW-1: out_exp = 2^EW-1, err=1.
- e < 0: out_exp = 0, err=1.

FSM:
- ACC: on fire with a_last|b_last, go to FLUSH. If a_last != b_last, set err=1 and treat the beat as last.
- FLUSH: exactly one cycle; the last products are added; go to OUT.
- OUT: out_valid=1; out_prod, out_exp and out_err are stable. On out_ready, go to ACC and clear acc and err on that same edge.

Latency and throughput:
- Last beat fires at edge t; out_valid is high from t+2.
- Minimum period is N+2 cycles for an N-beat vector with out_ready held high.
- No new beats are accepted in FLUSH or OUT; backpressure propagates through a_ready/b_ready.
- More than V/P beats without a last flag: force last on beat V/P and set err.

Reset mid-vector: partial accumulation is discarded; the next beat after release starts a fresh vector.

Decomposition:
- Package bfp_pkg holds EW, MW, OW and BIAS as functions of the parameters, a bfp_mant_t packed struct {sign, mag}, and the FSM enum state_t {ACC, FLUSH, OUT}.
- One sub-module, bfp_lane_mult: sign-magnitude multiply producing a signed product, instantiated P times.
- Adder tree and FSM stay in the top module.

Test Plan:
- Two-beat vector, all lanes a=b=+24 (1.5), a_exp=127, b_exp=128 -> out_prod=4608, out_exp=128, err=0; out_valid rises 2 cycles after the last beat.
- Lanes of A alternate sign (+24,-24,+24,-24), B all +24, two beats -> out_prod=0. Then a_mants all -31, b_mants all +31 -> out_prod=-7688.
- Single beat with last=1, a=b=+24 -> out_prod=2304. Back-to-back next vector with out_ready=1 is accepted 3 cycles after the previous last beat.
- out_ready held low 5 cycles in OUT -> a_ready=b_ready=0 throughout and out_prod stable; release -> exactly one result transfers, and the next vector is unaffected by the old acc.
- a_exp=b_exp=254 -> out_exp=255, err=1. a_exp=b_exp=10 -> out_exp=0, err=1. a_last=1 with b_last=0 -> err=1 and the vector closes.
- reset pulsed low after beat 1 of 2 -> outputs clear immediately. A subsequent 2-beat all-24 vector yields 4608, not a corrupted sum.

Source files
------------

// File: rtl/bfp_pkg.sv
// Shared sizing helpers, default mantissa layout and FSM encoding for the BFP dot-product stage.
// Widths are derived from the float/BFP parameters so every consumer agrees on them.
package bfp_pkg;

    localparam int BIT_DEF  = 32;
    localparam int FPM_DEF  = 23;
    localparam int BFPM_DEF = 4;

    function automatic int calc_ew(input int bit_w, input int fpm_w);
        return bit_w - fpm_w - 1;
    endfunction

    function automatic int calc_mw(input int bfpm_w);
        return bfpm_w + 2;
    endfunction

    // Room for 2*MW-bit products summed over up to V elements.
    function automatic int calc_ow(input int v_elems, input int bfpm_w);
        return 2 * calc_mw(bfpm_w) + $clog2(v_elems);
    endfunction

    function automatic int calc_bias(input int ew_w);
        return (1 << (ew_w - 1)) - 1;
    endfunction

    // Sign-magnitude mantissa word for the default BFP fraction width.
    typedef struct packed {
        logic                sign;
        logic [BFPM_DEF:0]   mag;
    } bfp_mant_t;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FLUSH = 2'd1,
        OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/bfp_lane_mult.sv
// One lane of sign-magnitude mantissa multiply, returned as a two's-complement product.
// Purely combinational; the caller registers the result.
module bfp_lane_mult
    import bfp_pkg::*;
#(
    parameter int BFPM = 4
) (
    input  logic [calc_mw(BFPM)-1:0]  a_i,
    input  logic [calc_mw(BFPM)-1:0]  b_i,
    output logic signed [2*BFPM+2:0]  prod_o
);

    localparam int MW = calc_mw(BFPM);
    localparam int HW = BFPM + 1;

    logic [2*HW-1:0] mag;
    logic            neg;

    assign mag    = {{HW{1'b0}}, a_i[BFPM:0]} * {{HW{1'b0}}, b_i[BFPM:0]};
    assign neg    = a_i[MW-1] ^ b_i[MW-1];
    assign prod_o = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});

endmodule

// File: rtl/bfp_dot_accum.sv
// Joins A/B BFP chunk streams, multiplies lane-wise, tree-reduces and accumulates one dot product per vector.
// Result valid two edges after the last beat fires; inputs stall (a_ready=b_ready=0) in FLUSH/OUT until out_ready.
module bfp_dot_accum
    import bfp_pkg::*;
#(
    parameter int V    = 8,
    parameter int P    = 4,
    parameter int BIT  = 32,
    parameter int FPM  = 23,
    parameter int BFPM = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                a_valid,
    output logic                                a_ready,
    input  logic [P*calc_mw(BFPM)-1:0]          a_mants,
    input  logic [calc_ew(BIT, FPM)-1:0]        a_exp,
    input  logic                                a_last,
    input  logic                                b_valid,
    output logic                                b_ready,
    input  logic [P*calc_mw(BFPM)-1:0]          b_mants,
    input  logic [calc_ew(BIT, FPM)-1:0]        b_exp,
    input  logic                                b_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [calc_ow(V, BFPM)-1:0]  out_prod,
    output logic [calc_ew(BIT, FPM)-1:0]        out_exp,
    output logic                                out_err
);

    localparam int EW   = calc_ew(BIT, FPM);
    localparam int MW   = calc_mw(BFPM);
    localparam int OW   = calc_ow(V, BFPM);
    localparam int BIAS = calc_bias(EW);
    localparam int PW   = 2 * (BFPM + 1) + 1;
    localparam int NB   = V / P;
    localparam int CW   = (NB > 1) ? $clog2(NB) : 1;

    state_t                 state_q, state_d;
    logic                   fire, close, mism, forced, xfer;

    logic signed [PW-1:0]   lane_prod [P];
    logic signed [PW-1:0]   prod_q    [P];
    logic                   prod_vld_q;

    logic signed [OW-1:0]   tree [1:2*P-1];
    logic signed [OW-1:0]   acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [EW-1:0]          ea_q, ea_d, eb_q, eb_d;
    logic                   err_q, err_d;

    logic signed [EW+1:0]   e_sum;
    logic [EW-1:0]          e_sat;
    logic                   e_bad;

    // Join: a beat is taken from both channels together or not at all.
    assign fire    = reset & (state_q == ACC) & a_valid & b_valid;
    assign a_ready = fire;
    assign b_ready = fire;

    assign mism    = a_last ^ b_last;
    assign forced  = (cnt_q == CW'(NB - 1)) & ~a_last & ~b_last;
    assign close   = a_last | b_last | forced;

    assign out_valid = (state_q == OUT);
    assign xfer      = out_valid & out_ready;

    for (genvar g = 0; g < P; g++) begin : g_lane
        bfp_lane_mult #(.BFPM(BFPM)) u_mult (
            .a_i    (a_mants[g*MW +: MW]),
            .b_i    (b_mants[g*MW +: MW]),
            .prod_o (lane_prod[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_vld_q <= 1'b0;
            for (int i = 0; i < P; i++) prod_q[i] <= '0;
        end else begin
            prod_vld_q <= fire;
            if (fire) begin
                for (int i = 0; i < P; i++) prod_q[i] <= lane_prod[i];
            end
        end
    end

    // Heap-ordered adder tree: leaves at P..2P-1, node i sums children 2i and 2i+1, root at 1.
    always_comb begin
        for (int i = 0; i < P; i++) tree[P+i] = OW'(prod_q[i]);
        for (int i = P - 1; i >= 1; i--) tree[i] = tree[2*i] + tree[2*i+1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        err_d   = err_q;
        acc_d   = acc_q;
        if (prod_vld_q) acc_d = acc_q + tree[1];
        case (state_q)
            ACC: begin
                if (fire) begin
                    if (cnt_q == '0) begin
                        ea_d = a_exp;
                        eb_d = b_exp;
                    end
                    if (mism || forced) err_d = 1'b1;
                    if (close) begin
                        state_d = FLUSH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            FLUSH: state_d = OUT;
            OUT: begin
                if (xfer) begin
                    state_d = ACC;
                    acc_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ACC;
            cnt_q   <= '0;
            ea_q    <= '0;
            eb_q    <= '0;
            err_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
        end
    end

    // Two guard bits let the biased sum go negative or past the exponent range without wrapping.
    assign e_sum = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - $signed((EW+2)'(BIAS));

    always_comb begin
        e_sat = e_sum[EW-1:0];
        e_bad = 1'b0;
        if (e_sum[EW+1]) begin
            e_sat = '0;
            e_bad = 1'b1;
        end else if (e_sum[EW]) begin
            e_sat = '1;
            e_bad = 1'b1;
        end
    end

    assign out_prod = out_valid ? acc_q : '0;
    assign out_exp  = out_valid ? e_sat : '0;
    assign out_err  = out_valid & (err_q | e_bad);

endmodule

// File: tb/tb_bfp_dot_accum.sv
// Directed self-checking bench for bfp_dot_accum with default parameters (P=4, MW=6, EW=8, OW=15).
module tb_bfp_dot_accum;
    import bfp_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               a_valid, b_valid, a_last, b_last, out_ready;
    logic [23:0]        a_mants, b_mants;
    logic [7:0]         a_exp, b_exp;
    logic               a_ready, b_ready, out_valid, out_err;
    logic signed [14:0] out_prod;
    logic [7:0]         out_exp;

    int total = 0;
    int bad   = 0;

    logic [23:0] l24, l31, ln31, lalt;

    bfp_dot_accum dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_mants   (a_mants),
        .a_exp     (a_exp),
        .a_last    (a_last),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_mants   (b_mants),
        .b_exp     (b_exp),
        .b_last    (b_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_exp   (out_exp),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [23:0] lanes4(input int m0, input int m1, input int m2, input int m3);
        logic [23:0] r;
        bfp_mant_t   m;
        int          v[4];
        v[0] = m0; v[1] = m1; v[2] = m2; v[3] = m3;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            m.sign = (v[i] < 0);
            m.mag  = 5'((v[i] < 0) ? -v[i] : v[i]);
            r[i*6 +: 6] = m;
        end
        return r;
    endfunction

    // Presents one joined beat and waits (bounded) until it fires; returns one time unit after the firing edge.
    task automatic send_beat(input logic [23:0] am, input logic [23:0] bm, input logic [7:0] ae,
                             input logic [7:0] be, input logic al, input logic bl, output bit ok);
        a_mants = am; b_mants = bm; a_exp = ae; b_exp = be;
        a_last = al; b_last = bl; a_valid = 1'b1; b_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (a_ready && b_ready) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
        end
        a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
    endtask

    task automatic wait_out(output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        for (int n = 0; n < 20; n++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
        a_last = 1'b1; b_last = 1'b1; a_mants = l24; b_mants = l24; a_exp = 8'd127; b_exp = 8'd127;
        @(posedge clk); #1;
        total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: a=%b b=%b want 0 0", a_ready, b_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (out_prod !== 15'sd0 || out_exp !== 8'd0 || out_err !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: prod=%0d exp=%0d err=%b want 0 0 0", out_prod, out_exp, out_err);
        end
        a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit ok; int cyc;
        send_beat(l24, l24, 8'd127, 8'd128, 1'b0, 1'b0, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_beat1: fired=%b want 1", ok); end
        send_beat(l24, l24, 8'd200, 8'd200, 1'b1, 1'b1, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_beat2: fired=%b want 1", ok); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_flush_valid: got %b want 0", out_valid); end
        wait_out(cyc, ok);
        total++; if (!ok || cyc != 1) begin bad++; $display("FAIL basic_latency: seen=%b extra_cycles=%0d want 1 1", ok, cyc); end
        total++; if (out_prod !== 15'sd4608) begin bad++; $display("FAIL basic_prod: got %0d want 4608", out_prod); end
        total++; if (out_exp !== 8'd128 || out_err !== 1'b0) begin bad++; $display("FAIL basic_exp: exp=%0d err=%b want 128 0", out_exp, out_err); end
        consume();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_signs();
        bit ok; int cyc;
        send_beat(lalt, l24, 8'd127, 8'd127, 1'b0, 1'b0, ok);
        send_beat(lalt, l24, 8'd127, 8'd127, 1'b1, 1'b1, ok);
        wait_out(cyc, ok);
        total++; if (!ok || out_prod !== 15'sd0) begin bad++; $display("FAIL signs_cancel: seen=%b got %0d want 0", ok, out_prod); end
        total++; if (out_exp !== 8'd127 || out_err !== 1'b0) begin bad++; $display("FAIL signs_exp: exp=%0d err=%b want 127 0", out_exp, out_err); end
        consume();
        send_beat(ln31, l31, 8'd127, 8'd127, 1'b0, 1'b0, ok);
        send_beat(ln31, l31, 8'd127, 8'd127, 1'b1, 1'b1, ok);
        wait_out(cyc, ok);
        total++; if (!ok || out_prod !== -15'sd7688) begin bad++; $display("FAIL signs_neg: seen=%b got %0d want -7688", ok, out_prod); end
        consume();
    endtask

    task automatic test_back_to_back();
        bit ok;
        out_ready = 1'b1;
        send_beat(l24, l24, 8'd127, 8'd127, 1'b1, 1'b1, ok);
        a_mants = l31; b_mants = l31; a_last = 1'b1; b_last = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        #1;
        total++; if (a_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL b2b_flush: ready=%b valid=%b want 0 0", a_ready, out_valid); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || out_prod !== 15'sd2304) begin bad++; $display("FAIL b2b_first: valid=%b prod=%0d want 1 2304", out_valid, out_prod); end
        total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin bad++; $display("FAIL b2b_out_ready: a=%b b=%b want 0 0", a_ready, b_ready); end
        @(posedge clk); #1;
        total++; if (a_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL b2b_accept: ready=%b valid=%b want 1 0", a_ready, out_valid); end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || out_prod !== 15'sd3844) begin bad++; $display("FAIL b2b_second: valid=%b prod=%0d want 1 3844", out_valid, out_prod); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_stall();
        bit ok; int cyc;
        send_beat(l24, l24, 8'd127, 8'd127, 1'b0, 1'b0, ok);
        send_beat(l24, l24, 8'd127, 8'd127, 1'b1, 1'b1, ok);
        wait_out(cyc, ok);
        a_mants = l31; b_mants = l24; a_exp = 8'd127; b_exp = 8'd127; a_valid = 1'b1; b_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1;
            total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d]: a=%b b=%b want 0 0", n, a_ready, b_ready); end
            total++; if (out_valid !== 1'b1 || out_prod !== 15'sd4608) begin bad++; $display("FAIL stall_hold[%0d]: valid=%b prod=%0d want 1 4608", n, out_valid, out_prod); end
            @(posedge clk); #1;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        consume();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_single_xfer: valid=%b want 0", out_valid); end
        send_beat(l31, l24, 8'd127, 8'd127, 1'b0, 1'b0, ok);
        send_beat(l31, l24, 8'd127, 8'd127, 1'b1, 1'b1, ok);
        wait_out(cyc, ok);
        total++; if (!ok || out_prod !== 15'sd5952) begin bad++; $display("FAIL stall_next: seen=%b got %0d want 5952", ok, out_prod); end
        consume();
    endtask

    task automatic test_exp_err();
        bit ok; int cyc;
        send_beat(l24, l24, 8'd254, 8'd254, 1'b1, 1'b1, ok);
        wait_out(cyc, ok);
        total++; if (!ok || out_exp !== 8'd255 || out_err !== 1'b1) begin bad++; $display("FAIL exp_over: exp=%0d err=%b want 255 1", out_exp, out_err); end
        consume();
        send_beat(l24, l24, 8'd10, 8'd10, 1'b1, 1'b1, ok);
        wait_out(cyc, ok);
        total++; if (!ok || out_exp !== 8'd0 || out_err !== 1'b1) begin bad++; $display("FAIL exp_under: exp=%0d err=%b want 0 1", out_exp, out_err); end
        consume();
        send_beat(l24, l24, 8'd127, 8'd127, 1'b1, 1'b0, ok);
        wait_out(cyc, ok);
        total++; if (!ok || out_err !== 1'b1 || out_prod !== 15'sd2304) begin bad++; $display("FAIL last_mismatch: seen=%b err=%b prod=%0d want 1 1 2304", ok, out_err, out_prod); end
        consume();
        send_beat(l24, l24, 8'd127, 8'd127, 1'b0, 1'b0, ok);
        send_beat(l24, l24, 8'd127, 8'd127, 1'b0, 1'b0, ok);
        wait_out(cyc, ok);
        total++; if (!ok || out_err !== 1'b1 || out_prod !== 15'sd4608) begin bad++; $display("FAIL forced_last: seen=%b err=%b prod=%0d want 1 1 4608", ok, out_err, out_prod); end
        consume();
        send_beat(l24, l24, 8'd127, 8'd128, 1'b1, 1'b1, ok);
        wait_out(cyc, ok);
        total++; if (!ok || out_err !== 1'b0 || out_exp !== 8'd128) begin bad++; $display("FAIL err_cleared: err=%b exp=%0d want 0 128", out_err, out_exp); end
        consume();
    endtask

    task automatic test_reset_mid();
        bit ok; int cyc;
        send_beat(l24, l24, 8'd127, 8'd127, 1'b1, 1'b1, ok);
        wait_out(cyc, ok);
        reset = 1'b0; #2;
        total++; if (out_valid !== 1'b0 || out_prod !== 15'sd0) begin bad++; $display("FAIL reset_in_out: valid=%b prod=%0d want 0 0", out_valid, out_prod); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        send_beat(l31, l31, 8'd127, 8'd127, 1'b0, 1'b0, ok);
        a_mants = l24; b_mants = l24; a_valid = 1'b1; b_valid = 1'b1;
        reset = 1'b0; #2;
        total++; if (a_ready !== 1'b0 || b_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_mid_clear: a=%b b=%b valid=%b want 0 0 0", a_ready, b_ready, out_valid);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        send_beat(l24, l24, 8'd127, 8'd127, 1'b0, 1'b0, ok);
        send_beat(l24, l24, 8'd127, 8'd127, 1'b1, 1'b1, ok);
        wait_out(cyc, ok);
        total++; if (!ok || out_prod !== 15'sd4608 || out_err !== 1'b0) begin bad++; $display("FAIL reset_mid_fresh: seen=%b prod=%0d err=%b want 1 4608 0", ok, out_prod, out_err); end
        consume();
    endtask

    initial begin
        l24  = lanes4(24, 24, 24, 24);
        l31  = lanes4(31, 31, 31, 31);
        ln31 = lanes4(-31, -31, -31, -31);
        lalt = lanes4(24, -24, 24, -24);
        a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0; out_ready = 1'b0;
        a_mants = '0; b_mants = '0; a_exp = '0; b_exp = '0; reset = 1'b0;
        test_reset();
        test_basic();
        test_signs();
        test_back_to_back();
        test_stall();
        test_exp_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
